// File: rtl/rng_word_packer.sv
// Packs a serial LFSR bit stream into words with a repetition-count health
// test and drains completed words through a small valid/ready FIFO.
module rng_word_packer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 17,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
  output logic              stuck_err
);

  localparam int CW = $clog2(WORD_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-2:0] shreg;
  logic [RW-1:0]     run;
  logic              last_bit;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              valid_q;
  logic [WORD_W-1:0] head_q;
  logic              ovf_q;
  logic              stuck_q;

  logic [WORD_W-1:0] word_nxt;
  logic [RW-1:0]     run_nxt;
  logic              complete;
  logic              stuck_hit;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              push;
  logic              ovf_set;
  logic [LW-1:0]     level_nxt;
  logic [PW-1:0]     wr_ptr_nxt;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [WORD_W-1:0] head_nxt;

  always_comb begin
    word_nxt = {shreg, bit_in};
    run_nxt  = run;
    if (run == '0 || bit_in != last_bit)
      run_nxt = RW'(1);
    else if (run != RW'(REP_LIMIT))
      run_nxt = run + RW'(1);
    complete  = bit_en && (bit_cnt == CW'(WORD_W - 1));
    stuck_hit = bit_en && (run_nxt == RW'(REP_LIMIT));
    // Words finishing while the source is (or just became) stuck are dropped
    push_req  = complete && !stuck_q && !stuck_hit;
    pop       = valid_q && out_ready;
    full      = (level == LW'(FIFO_DEPTH));
    push      = push_req && (!full || pop);
    ovf_set   = push_req && full && !pop;
    level_nxt = level;
    unique case (1'b1)
      push && !pop: level_nxt = level + LW'(1);
      pop && !push: level_nxt = level - LW'(1);
      default:      level_nxt = level;
    endcase
    wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    // New head is the incoming word when it becomes the only entry
    unique case (1'b1)
      level_nxt == '0:          head_nxt = '0;
      push && level_nxt == 1:   head_nxt = word_nxt;
      default:                  head_nxt = mem[rd_ptr_nxt];
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      run      <= '0;
      last_bit <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      stuck_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (clear) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      run      <= '0;
      last_bit <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      stuck_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (bit_en) begin
        bit_cnt  <= complete ? '0 : bit_cnt + CW'(1);
        shreg    <= word_nxt[WORD_W-2:0];
        run      <= run_nxt;
        last_bit <= bit_in;
      end
      if (push)
        mem[wr_ptr] <= word_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      valid_q <= (level_nxt != '0);
      head_q  <= head_nxt;
      if (ovf_set)
        ovf_q <= 1'b1;
      if (stuck_hit)
        stuck_q <= 1'b1;
    end
  end

  assign out_data   = head_q;
  assign out_valid  = valid_q;
  assign fifo_level = level;
  assign overflow   = ovf_q;
  assign stuck_err  = stuck_q;

endmodule

// File: tb/tb_rng_word_packer.sv
// Directed bench for rng_word_packer with a queue-based reference model
// compared after every clock edge.
module tb_rng_word_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       stuck_err;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] mq [$];
  int mcnt, macc, mrun, mfirst, mlast, movf, mstuck;

  rng_word_packer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bit_in(bit_in), .bit_en(bit_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcnt = 0; macc = 0; mrun = 0; mfirst = 1; mlast = 0;
    movf = 0; mstuck = 0;
  endtask

  task automatic model_step(input logic en, input logic b,
                            input logic rdy, input logic clr);
    bit pop, push_req, hit;
    if (clr) begin
      model_reset();
      return;
    end
    pop = (mq.size() != 0) && rdy;
    push_req = 0;
    if (en) begin
      if (mfirst != 0 || int'(b) != mlast) mrun = 1;
      else if (mrun < 17) mrun++;
      mfirst = 0;
      mlast = int'(b);
      hit = (mrun == 17);
      macc = ((macc * 2) + int'(b)) % 256;
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        push_req = (mstuck == 0) && !hit;
      end
      if (hit) mstuck = 1;
    end
    if (pop) void'(mq.pop_front());
    if (push_req) begin
      if (mq.size() < 4) mq.push_back(8'(macc));
      else movf = 1;
    end
  endtask

  task automatic compare();
    chk("level", int'(fifo_level), mq.size());
    chk("valid", int'(out_valid), int'(mq.size() != 0));
    chk("overflow", int'(overflow), movf);
    chk("stuck", int'(stuck_err), mstuck);
    if (mq.size() != 0) chk("data", int'(out_data), int'(mq[0]));
  endtask

  task automatic tick(input logic en, input logic b,
                      input logic rdy, input logic clr);
    @(negedge clk);
    bit_en = en; bit_in = b; out_ready = rdy; clear = clr;
    @(posedge clk);
    model_step(en, b, rdy, clr);
    #1;
    compare();
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 0; i--)
      tick(1'b1, w[i], (i == 0) ? rdy_last : 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b1;
    #1;
    model_reset();
    rst_n = 1'b0;
    compare();
  endtask

  initial begin
    logic [7:0] v;
    model_reset();
    #12;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_flags", int'({overflow, stuck_err}), 0);

    // basic packing 1,0,1,0,0,1,0,1
    send_word(8'hA5, 1'b0);
    chk("a5_data", int'(out_data), 8'hA5);
    chk("a5_level", int'(fifo_level), 1);
    chk("a5_model", int'(mq[0]), 8'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // same bits with a 3-cycle bit_en gap
    v = 8'hA5;
    for (int i = 7; i >= 4; i--) tick(1'b1, v[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 1; i--) tick(1'b1, v[i], 1'b0, 1'b0);
    chk("gap_not_yet", int'(out_valid), 0);
    tick(1'b1, v[0], 1'b0, 1'b0);
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_data", int'(out_data), 8'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // overflow: five words into a four-deep FIFO
    for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0);
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", int'(out_data), k);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("ovf_empty", int'(out_valid), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    // full FIFO with simultaneous push and pop
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
    chk("pp_level", int'(fifo_level), 4);
    chk("pp_ovf", int'(overflow), 0);
    for (int k = 2; k <= 5; k++) begin
      chk("pp_drain", int'(out_data), k * 8'h11);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("pp_empty", int'(out_valid), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // 16 ones then a zero is healthy
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("run16_ok", int'(stuck_err), 0);
    chk("run16_level", int'(fifo_level), 2);
    // 16 more zeros (17 total), draining as we go
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("run16_zero_ok", int'(stuck_err), 0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stuck_set", int'(stuck_err), 1);
    chk("stuck_model", mstuck, 1);
    chk("stuck_level", int'(fifo_level), 0);
    send_word(8'hA5, 1'b0);
    send_word(8'h5A, 1'b0);
    chk("stuck_nopush", int'(fifo_level), 0);
    chk("stuck_noovf", int'(overflow), 0);
    chk("stuck_sticky", int'(stuck_err), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_all", int'({out_data, out_valid, fifo_level,
                         overflow, stuck_err}), 0);

    // reset mid-word, then a fresh word
    v = 8'hFF;
    for (int i = 0; i < 5; i++) tick(1'b1, v[i], 1'b0, 1'b0);
    pulse_reset();
    send_word(8'h3C, 1'b0);
    chk("rst_mid_data", int'(out_data), 8'h3C);
    chk("rst_mid_level", int'(fifo_level), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_word_packer.md
# rng_word_packer

Downstream consumer of the 16-bit maximal-length LFSR serial random bit. It samples the single-bit stream, runs a repetition-count health test on it, and packs the bits into WORD_W-bit words. Completed words go into a small FIFO and are drained over a valid/ready interface. This turns a free-running bit source into flow-controlled random words with stuck-source detection.

## Interface
- WORD_W, 8, bits per output word (≥2)
- FIFO_DEPTH, 4, word FIFO entries (power of two, ≥2)
- REP_LIMIT, 17, consecutive identical bits that flag a stuck source (a 16-bit max-length LFSR never exceeds a run of 16)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of all state; priority over every other input
- bit_in  in  1  serial random bit from the LFSR
- bit_en  in  1  sample bit_in on this edge
- out_data  out  WORD_W  FIFO head word, valid when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this edge
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently stored
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- stuck_err  out  1  sticky: a repetition-count failure has occurred

## Operation
- Reset (rst_n=1) or clear=1: bit counter 0, shift register 0, run counter 0, last-bit 0, FIFO empty (level 0, pointers 0), out_valid 0, out_data 0, overflow 0, stuck_err 0. Inputs sampled on a clear edge are ignored.
- Packing is MSB-first. The first sampled bit of a word lands in bit WORD_W-1 and the last in bit 0. Bit counter runs 0..WORD_W-1 and wraps to 0 on the edge that samples the last bit.
- The word completes on the edge that samples its WORD_W-th bit. The full word (including that bit) is pushed on that same edge.
- Health test on every sampled bit:
  - First bit after reset/clear: run=1.
  - bit equal to last-bit: run=min(run+1, REP_LIMIT).
  - bit different from last-bit: run=1.
  - stuck_err sets on the edge where run becomes REP_LIMIT.
- Push suppression: no push occurs while stuck_err is set, or on the edge where it sets. Packing continues and the words are discarded.
- Push with the FIFO full and no pop on that edge: the word is dropped, overflow sets, and FIFO contents are unchanged.
- Push with the FIFO full and a pop on the same edge: the push is accepted and the level stays at FIFO_DEPTH.
- Pop occurs when out_valid && out_ready. out_ready while empty has no effect.
- FIFO is in-order; pointers wrap modulo FIFO_DEPTH.
- fifo_level changes per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Sticky flags clear only on reset or clear.

## Timing
- out_data is the registered FIFO head. out_valid = (fifo_level != 0), both driven from registers.
- Latency: the word completing at edge k has out_valid=1 and out_data set in the cycle after k when the FIFO was empty. A pop at edge k+1 is the earliest.
- Throughput: one word per WORD_W bit_en cycles. Gaps in bit_en stall packing without losing state.
- overflow and stuck_err are visible in the cycle after the setting edge.
- Reset asserted mid-word or mid-drain aborts immediately and asynchronously. Partial words are lost, and the first word after release is built from fresh bits.

## Test plan
- Reset, then bit_en=1 with bits 1,0,1,0,0,1,0,1 and out_ready=0 → out_valid=1 after the 8th edge, out_data=8'hA5, fifo_level=1, flags 0.
- Same bits with bit_en deasserted for 3 cycles between bits 4 and 5 → out_data=8'hA5, out_valid rises exactly one cycle after the 8th sampled edge.
- out_ready=0, push words 8'h01,8'h02,8'h03,8'h04,8'h05 → level 4, overflow=1. Draining gives 01,02,03,04, then out_valid=0.
- FIFO full; the 8th bit of a new word arrives with out_ready=1 on the same edge → level stays 4, overflow=0, new word appears last in drain order.
- 16 ones then a 0 → stuck_err=0. Then 17 consecutive zeros → stuck_err=1 after the 17th edge, fifo_level never increases afterwards, and clear returns all outputs to 0.
- Reset pulse after 5 bits of a word; then 8'h3C fed MSB-first → out_data=8'h3C, no residue from the aborted bits.
